// File: rtl/proc_ctrl_fsm.sv
// ============================================================================
// proc_ctrl_fsm
// ----------------------------------------------------------------------------
// Controller state machine for the simple bus-based processor. Instructions
// are accepted over a valid/ready handshake, latched into an internal
// instruction register (IR), and sequenced through FETCH, DECODE and one of
// the execute flows (LOAD, MOVE, ADD/XOR). The bus-source and
// register-enable vectors are one-hot and decode only from the state
// register and IR.
//
// Parameters:
//   NREG : number of general registers (power of two, 2..16)
//   RAW  : register-field width, derived from NREG
//   IW   : instruction width, derived (2-bit opcode + Rx + Ry)
//
// Ports:
//   clock       in   rising-edge clock
//   resetn      in   asynchronous, active-low reset
//   instr       in   instruction {opcode, Rx, Ry}
//   instr_valid in   instr is valid
//   instr_ready out  controller is in FETCH and can accept an instruction
//   din_valid   in   load data on DIN is valid
//   din_ready   out  controller is sampling DIN onto the bus
//   rout        out  one-hot bus source: R0..R(NREG-1), G, DIN
//   ren         out  one-hot register enable: R0..R(NREG-1), A, G
//   alu_xor     out  ALU op select (0 = ADD, 1 = XOR)
//   increment   out  one-cycle PC-increment pulse
//   done        out  one-cycle instruction-complete pulse
//
// Configuration macro:
//   PROC_CTRL_DIN_HS_EN : when defined, the LOAD execute state waits for
//                         din_valid. When undefined, it lasts exactly one
//                         cycle and din_valid is ignored.
// ============================================================================
module proc_ctrl_fsm #(
    parameter int NREG = 8,
    parameter int RAW  = $clog2(NREG),
    parameter int IW   = 2 + 2*RAW
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [IW-1:0]   instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            din_valid,
    output logic            din_ready,
    output logic [NREG+1:0] rout,
    output logic [NREG+1:0] ren,
    output logic            alu_xor,
    output logic            increment,
    output logic            done
);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXEC_L   = 3'd2;
    localparam logic [2:0] S_EXEC_M   = 3'd3;
    localparam logic [2:0] S_EXEC_AX1 = 3'd4;
    localparam logic [2:0] S_EXEC_AX2 = 3'd5;
    localparam logic [2:0] S_EXEC_AX3 = 3'd6;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;

    logic [2:0]     state;
    logic [2:0]     state_next;
    logic [IW-1:0]  ir;
    logic [1:0]     opcode;
    logic [RAW-1:0] rx;
    logic [RAW-1:0] ry;
    logic           fetch_hs;
    logic           load_complete;

    assign opcode   = ir[IW-1:IW-2];
    assign rx       = ir[2*RAW-1:RAW];
    assign ry       = ir[RAW-1:0];
    assign fetch_hs = instr_valid && (state == S_FETCH);

`ifdef PROC_CTRL_DIN_HS_EN
    // The LOAD execute state finishes only once the data source says DIN is
    // valid; until then the bus source and enable stay held.
    assign load_complete = din_valid;
`else
    // Without the DIN handshake the data is assumed present immediately, so
    // the LOAD execute state always finishes in its first cycle.
    logic unused_din_valid;
    assign unused_din_valid = din_valid;
    assign load_complete    = 1'b1;
`endif

    // State register. Reset drops straight back to FETCH, which aborts any
    // instruction in flight; since every output decodes from this register,
    // the enables disappear the moment reset is asserted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register. It only captures on the FETCH handshake, so
    // whatever sits on instr during the execute states is ignored.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ir <= '0;
        end else if (fetch_hs) begin
            ir <= instr;
        end
    end

    // Next-state logic. ADD and XOR share the three-step A/G flow; they
    // differ only in the ALU select driven during the second step. The
    // spare encoding falls through to FETCH so a corrupted state recovers
    // on the next clock.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: begin
                state_next = fetch_hs ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (opcode == OP_LOAD) begin
                    state_next = S_EXEC_L;
                end else if (opcode == OP_MOVE) begin
                    state_next = S_EXEC_M;
                end else begin
                    state_next = S_EXEC_AX1;
                end
            end
            S_EXEC_L: begin
                state_next = load_complete ? S_FETCH : S_EXEC_L;
            end
            S_EXEC_M: begin
                state_next = S_FETCH;
            end
            S_EXEC_AX1: begin
                state_next = S_EXEC_AX2;
            end
            S_EXEC_AX2: begin
                state_next = S_EXEC_AX3;
            end
            S_EXEC_AX3: begin
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Output decode. Everything except done depends only on state and IR.
    // done in the LOAD state is the single output that follows an input
    // (din_valid) within the same cycle. Each state sets at most one rout
    // bit and at most one ren bit, which keeps both vectors one-hot.
    always_comb begin
        rout        = '0;
        ren         = '0;
        alu_xor     = 1'b0;
        increment   = 1'b0;
        done        = 1'b0;
        din_ready   = 1'b0;
        instr_ready = 1'b0;
        case (state)
            S_FETCH: begin
                instr_ready = 1'b1;
            end
            S_DECODE: begin
                increment = 1'b1;
            end
            S_EXEC_L: begin
                rout[NREG+1] = 1'b1;
                ren[rx]      = 1'b1;
                din_ready    = 1'b1;
                done         = load_complete;
            end
            S_EXEC_M: begin
                rout[ry] = 1'b1;
                ren[rx]  = 1'b1;
                done     = 1'b1;
            end
            S_EXEC_AX1: begin
                rout[rx]  = 1'b1;
                ren[NREG] = 1'b1;
            end
            S_EXEC_AX2: begin
                rout[ry]    = 1'b1;
                ren[NREG+1] = 1'b1;
                alu_xor     = opcode[0];
            end
            S_EXEC_AX3: begin
                rout[NREG] = 1'b1;
                ren[rx]    = 1'b1;
                done       = 1'b1;
            end
            default: begin
                rout = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// ============================================================================
// tb_proc_ctrl_fsm
// ----------------------------------------------------------------------------
// Directed bench for proc_ctrl_fsm with NREG=8 (IW=8). Each cycle's outputs
// are compared on the falling clock edge against hand-computed vectors.
// Honours PROC_CTRL_DIN_HS_EN for the LOAD expectations.
// ============================================================================
module tb_proc_ctrl_fsm;

    localparam int NREG = 8;
    localparam int IW   = 8;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_RDY  = 5'b10000;
    localparam logic [4:0] F_DRDY = 5'b01000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_INC  = 5'b00010;
    localparam logic [4:0] F_DONE = 5'b00001;

    logic            clock;
    logic            resetn;
    logic [IW-1:0]   instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            din_valid;
    logic            din_ready;
    logic [NREG+1:0] rout;
    logic [NREG+1:0] ren;
    logic            alu_xor;
    logic            increment;
    logic            done;

    int total_count;
    int bad_count;

    proc_ctrl_fsm #(.NREG(NREG)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .rout        (rout),
        .ren         (ren),
        .alu_xor     (alu_xor),
        .increment   (increment),
        .done        (done)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [IW-1:0] i_instr,
                                 input logic i_valid,
                                 input logic i_din_valid);
        instr       = i_instr;
        instr_valid = i_valid;
        din_valid   = i_din_valid;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string tag,
                              input logic [NREG+1:0] exp_rout,
                              input logic [NREG+1:0] exp_ren,
                              input logic [4:0] exp_flags);
        #1;
        checkOutput({tag, ".rout"}, 32'(rout), 32'(exp_rout));
        checkOutput({tag, ".ren"}, 32'(ren), 32'(exp_ren));
        checkOutput({tag, ".flags"},
                    32'({instr_ready, din_ready, alu_xor, increment, done}),
                    32'(exp_flags));
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;
        resetn      = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0);
        #1;
        checkCycle("reset", 10'h000, 10'h000, F_RDY);

        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkCycle("idle", 10'h000, 10'h000, F_RDY);
        end

        // ADD R3,R5 with junk held on instr during execute.
        applyStimulus(8'h9D, 1'b1, 1'b0);
        checkCycle("add_fetch", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        applyStimulus(8'h4E, 1'b1, 1'b0);
        checkCycle("add_decode", 10'h000, 10'h000, F_INC);
        @(negedge clock);
        checkCycle("add_ax1", 10'h008, 10'h100, F_NONE);
        @(negedge clock);
        checkCycle("add_ax2", 10'h020, 10'h200, F_NONE);
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("add_ax3", 10'h100, 10'h008, F_DONE);
        @(negedge clock);
        checkCycle("add_fetch6", 10'h000, 10'h000, F_RDY);

        // XOR R7,R0.
        applyStimulus(8'hF8, 1'b1, 1'b0);
        checkCycle("xor_fetch", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("xor_decode", 10'h000, 10'h000, F_INC);
        @(negedge clock);
        checkCycle("xor_ax1", 10'h080, 10'h100, F_NONE);
        @(negedge clock);
        checkCycle("xor_ax2", 10'h001, 10'h200, F_XOR);
        @(negedge clock);
        checkCycle("xor_ax3", 10'h100, 10'h080, F_DONE);
        @(negedge clock);
        checkCycle("xor_fetch_end", 10'h000, 10'h000, F_RDY);

        // LOAD R2.
        applyStimulus(8'h10, 1'b1, 1'b0);
        checkCycle("load_fetch", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("load_decode", 10'h000, 10'h000, F_INC);
`ifdef PROC_CTRL_DIN_HS_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkCycle("load_wait", 10'h200, 10'h004, F_DRDY);
        end
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkCycle("load_din", 10'h200, 10'h004, F_DRDY | F_DONE);
`else
        @(negedge clock);
        checkCycle("load_single", 10'h200, 10'h004, F_DRDY | F_DONE);
`endif
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("load_fetch_end", 10'h000, 10'h000, F_RDY);

        // MOVE R1,R6 then MOVE R6,R6 back to back.
        applyStimulus(8'h4E, 1'b1, 1'b0);
        checkCycle("move_fetch", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("move_decode", 10'h000, 10'h000, F_INC);
        @(negedge clock);
        checkCycle("move_exec", 10'h040, 10'h002, F_DONE);
        @(negedge clock);
        applyStimulus(8'h76, 1'b1, 1'b0);
        checkCycle("move2_fetch", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("move2_decode", 10'h000, 10'h000, F_INC);
        @(negedge clock);
        checkCycle("move2_exec", 10'h040, 10'h040, F_DONE);
        @(negedge clock);
        checkCycle("move2_fetch_end", 10'h000, 10'h000, F_RDY);

        // ADD R3,R5 aborted by reset during the second execute step.
        applyStimulus(8'h9D, 1'b1, 1'b0);
        checkCycle("abort_fetch", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("abort_decode", 10'h000, 10'h000, F_INC);
        @(negedge clock);
        checkCycle("abort_ax1", 10'h008, 10'h100, F_NONE);
        @(negedge clock);
        checkCycle("abort_ax2", 10'h020, 10'h200, F_NONE);
        #1;
        resetn = 1'b0;
        checkCycle("abort_async", 10'h000, 10'h000, F_RDY);
        @(posedge clock);
        checkCycle("abort_hold", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        resetn = 1'b1;
        checkCycle("abort_release", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        checkCycle("abort_no_done", 10'h000, 10'h000, F_RDY);

        // Normal instruction after the abort.
        applyStimulus(8'h4E, 1'b1, 1'b0);
        checkCycle("post_fetch", 10'h000, 10'h000, F_RDY);
        @(negedge clock);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkCycle("post_decode", 10'h000, 10'h000, F_INC);
        @(negedge clock);
        checkCycle("post_exec", 10'h040, 10'h002, F_DONE);
        @(negedge clock);
        checkCycle("post_fetch_end", 10'h000, 10'h000, F_RDY);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
